// File: rtl/game_flow_ctrl_if.sv
// Game-flow bus: keyboard and game events in, mode flags and level/lives counts out.
// The master side drives the events; the controller sits on the slave side.
interface game_flow_ctrl_if #(
    parameter int KEY_W = 8
);
    logic [KEY_W-1:0] keycode;
    logic             frame_tick;
    logic             player_hit;
    logic             wave_cleared;
    logic             start;
    logic             level_start;
    logic             is_playing;
    logic             is_paused;
    logic             is_finished;
    logic             is_victory;
    logic [3:0]       lives;
    logic [3:0]       level;

    modport master (
        output keycode, frame_tick, player_hit, wave_cleared,
        input  start, level_start, is_playing, is_paused, is_finished, is_victory,
        input  lives, level
    );

    modport slave (
        input  keycode, frame_tick, player_hit, wave_cleared,
        output start, level_start, is_playing, is_paused, is_finished, is_victory,
        output lives, level
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Space Invaders game sequencer: attract, multi-wave play, pause, inter-level gap,
// game over and victory, with registered mode flags and level/lives counts.
//
// state       | meaning
// ATTRACT     | idle after reset, any key starts a game
// START       | one-cycle new-game setup (start + level_start pulses)
// PLAYING     | wave in progress
// PAUSED      | game frozen until the pause key is pressed again
// LEVEL_CLEAR | countdown of frame ticks between waves
// GAME_OVER   | out of lives, restart key begins a new game
// VICTORY     | all waves cleared, restart key begins a new game
module game_flow_ctrl #(
    parameter int               KEY_W            = 8,
    parameter int               NUM_LEVELS       = 4,
    parameter int               START_LIVES      = 3,
    parameter int               LEVEL_GAP_FRAMES = 120,
    parameter logic [KEY_W-1:0] PAUSE_KEY        = KEY_W'(19),
    parameter logic [KEY_W-1:0] RESTART_KEY      = KEY_W'(44)
) (
    input  logic              clk,
    input  logic              reset,
    game_flow_ctrl_if.slave   bus
);

    localparam int GAP_W = $clog2(LEVEL_GAP_FRAMES + 1);

    typedef enum logic [2:0] {
        ATTRACT     = 3'd0,
        START       = 3'd1,
        PLAYING     = 3'd2,
        PAUSED      = 3'd3,
        LEVEL_CLEAR = 3'd4,
        GAME_OVER   = 3'd5,
        VICTORY     = 3'd6
    } state_t;

    state_t           state;
    logic [3:0]       flags;   // {is_playing, is_paused, is_finished, is_victory}
    logic             start_r;
    logic             level_start_r;
    logic [3:0]       lives_r;
    logic [3:0]       level_r;
    logic [KEY_W-1:0] key_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             kp;

    assign kp = (bus.keycode != '0) && (bus.keycode != key_q);

    function automatic logic [3:0] flags_of(input state_t s);
        case (s)
            PLAYING:   flags_of = 4'b1000;
            PAUSED:    flags_of = 4'b0100;
            GAME_OVER: flags_of = 4'b0010;
            VICTORY:   flags_of = 4'b0011;
            default:   flags_of = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ATTRACT;
            flags         <= '0;
            start_r       <= 1'b0;
            level_start_r <= 1'b0;
            lives_r       <= '0;
            level_r       <= '0;
            key_q         <= '0;
            gap_cnt       <= '0;
        end else begin
            key_q         <= bus.keycode;
            start_r       <= 1'b0;
            level_start_r <= 1'b0;
            case (state)
                ATTRACT: begin
                    if (kp) begin
                        state         <= START;
                        flags         <= flags_of(START);
                        start_r       <= 1'b1;
                        level_start_r <= 1'b1;
                        lives_r       <= 4'(START_LIVES);
                        level_r       <= 4'd1;
                    end
                end
                START: begin
                    state <= PLAYING;
                    flags <= flags_of(PLAYING);
                end
                PLAYING: begin
                    // A fatal hit outranks a same-cycle wave clear.
                    if (bus.player_hit && lives_r <= 4'd1) begin
                        state   <= GAME_OVER;
                        flags   <= flags_of(GAME_OVER);
                        lives_r <= '0;
                    end else begin
                        if (bus.player_hit)
                            lives_r <= lives_r - 4'd1;
                        if (bus.wave_cleared) begin
                            if (level_r >= 4'(NUM_LEVELS)) begin
                                state <= VICTORY;
                                flags <= flags_of(VICTORY);
                            end else begin
                                state   <= LEVEL_CLEAR;
                                flags   <= flags_of(LEVEL_CLEAR);
                                gap_cnt <= GAP_W'(LEVEL_GAP_FRAMES);
                            end
                        end else if (kp && bus.keycode == PAUSE_KEY) begin
                            state <= PAUSED;
                            flags <= flags_of(PAUSED);
                        end
                    end
                end
                PAUSED: begin
                    if (kp && bus.keycode == PAUSE_KEY) begin
                        state <= PLAYING;
                        flags <= flags_of(PLAYING);
                    end
                end
                LEVEL_CLEAR: begin
                    if (bus.frame_tick) begin
                        if (gap_cnt <= GAP_W'(1)) begin
                            state         <= PLAYING;
                            flags         <= flags_of(PLAYING);
                            level_start_r <= 1'b1;
                            gap_cnt       <= '0;
                            if (level_r < 4'(NUM_LEVELS))
                                level_r <= level_r + 4'd1;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                end
                GAME_OVER, VICTORY: begin
                    if (kp && bus.keycode == RESTART_KEY) begin
                        state         <= START;
                        flags         <= flags_of(START);
                        start_r       <= 1'b1;
                        level_start_r <= 1'b1;
                        lives_r       <= 4'(START_LIVES);
                        level_r       <= 4'd1;
                    end
                end
                default: begin
                    state   <= ATTRACT;
                    flags   <= '0;
                    lives_r <= '0;
                    level_r <= '0;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.start       = start_r;
    assign bus.level_start = level_start_r;
    assign bus.is_playing  = flags[3];
    assign bus.is_paused   = flags[2];
    assign bus.is_finished = flags[1];
    assign bus.is_victory  = flags[0];
    assign bus.lives       = lives_r;
    assign bus.level       = level_r;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the Space Invaders design; parametrised successor to the single-game start/over controller.
- Adds multi-level waves, a lives counter, pause/resume, an inter-level countdown and a victory end state.
- Sits between the keyboard keycode path and the sprite/score/render logic.
- Drives the mode flags and the level and lives counts consumed downstream.

Parameters:
- KEY_W, 8: keycode width.
- NUM_LEVELS, 4: waves per game; range 1..15.
- START_LIVES, 3: lives at game start; range 1..15.
- LEVEL_GAP_FRAMES, 120: frame_tick count spent in LEVEL_CLEAR; must be >=1.
- PAUSE_KEY, 8'd19: keycode that toggles pause ('P').
- RESTART_KEY, 8'd44: keycode that restarts from an end state (space).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- keycode  in  KEY_W  current keyboard code; 0 = no key.
- frame_tick  in  1  one-cycle pulse per video frame.
- player_hit  in  1  one-cycle pulse: player destroyed.
- wave_cleared  in  1  one-cycle pulse: all invaders of the current wave destroyed.
- start  out  1  high for exactly one cycle when a new game begins.
- level_start  out  1  one-cycle pulse when a new wave begins (also asserted with start).
- is_playing  out  1  high in PLAYING.
- is_paused  out  1  high in PAUSED.
- is_finished  out  1  high in GAME_OVER or VICTORY.
- is_victory  out  1  high in VICTORY.
- lives  out  4  remaining lives.
- level  out  4  current wave, 1..NUM_LEVELS; 0 in ATTRACT.

Behaviour:
- Reset is asynchronous; clock is clk only.
- Reset state and values: state=ATTRACT; all outputs 0; lives=0; level=0; key_q=0; gap counter=0.
- Reset asserted mid-game has the same effect at once, with no pulse emitted.
- Key press event (kp): keycode!=0 && keycode!=key_q, where key_q is keycode registered every cycle. A held key produces exactly one kp.
- All outputs are registered. Flags reflect the current state; pulses are asserted in the cycle that state is entered.
- ATTRACT: any kp -> START.
- START (1 cycle):
  - start=1, level_start=1, lives<=START_LIVES, level<=1.
  - -> PLAYING unconditionally.
- PLAYING, evaluated in this order within one cycle:
  1. player_hit: lives<=lives-1. If lives==1, -> GAME_OVER (lives=0) and ignore the rest.
  2. wave_cleared: if level==NUM_LEVELS, -> VICTORY. Otherwise -> LEVEL_CLEAR and gap counter<=LEVEL_GAP_FRAMES.
  3. kp && keycode==PAUSE_KEY (only if neither 1 nor 2 changed state): -> PAUSED.
  - Hit and clear in the same cycle with lives>1: decrement and the clear transition both take effect.
- PAUSED:
  - player_hit, wave_cleared and frame_tick are ignored; lives and level are held.
  - kp && keycode==PAUSE_KEY -> PLAYING. Other keys are ignored.
- LEVEL_CLEAR:
  - is_playing=0.
  - On frame_tick: if counter==1, level<=level+1, level_start=1, -> PLAYING. Otherwise counter<=counter-1.
  - player_hit and wave_cleared are ignored; pause key is ignored.
- GAME_OVER and VICTORY:
  - Hold lives and level for score display.
  - kp && keycode==RESTART_KEY -> START. Other keys are ignored.
- Unreachable or illegal encodings -> ATTRACT on the next clock.
- Level never exceeds NUM_LEVELS; lives never underflow below 0.
- With NUM_LEVELS=1, the first wave_cleared goes straight to VICTORY.

Test Plan:
1. Reset, then keycode=0x04 held 10 cycles -> single start pulse 1 cycle after kp, then is_playing=1, lives=3, level=1. No second start while the key is held.
2. PLAYING, lives=3, three player_hit pulses 5 cycles apart -> lives 2,1, then 0 with is_finished=1, is_victory=0. keycode=44 -> start pulse, lives=3, level=1.
3. LEVEL_GAP_FRAMES=3, wave_cleared at level 1 -> is_playing=0. On the 3rd frame_tick: level=2, level_start pulse, is_playing=1. A player_hit during the gap leaves lives unchanged.
4. NUM_LEVELS=2, clear both waves -> is_victory=1 and is_finished=1 with level=2 held. Non-space keys are ignored.
5. Press/release 'P' (19) -> is_paused=1. player_hit and wave_cleared while paused cause no change. Second 'P' press -> is_playing=1, lives unchanged.
6. Same-cycle player_hit+wave_cleared at lives=2 -> lives=1, LEVEL_CLEAR. At lives=1 -> GAME_OVER. Async reset asserted mid-LEVEL_CLEAR -> all outputs 0 immediately, without waiting for a clk edge.
